instr_fetch_unit: RTL

// - Upstream neighbour of the single-cycle core. Issues pipelined, in-order reads to a latency-tolerant

---
 rtl/rv_core_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/rv_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_core_pkg
//  Description : Shared core constants and the fetch-entry {instr, pc} type.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_core_pkg;

    localparam int              XLEN             = 32;
    localparam int              INSTR_W          = 32;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP           = 32'h0000_0013;

    // One buffered fetch result: instruction word plus the address it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous FIFO of fetch entries. Flush beats push/pop;
//                push and pop together are both honoured even when full.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import rv_core_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  fetch_entry_t  wdata_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // Head is presented as zero when nothing is buffered.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is legal only when the head leaves the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    // Storage array; unreset because reads are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Pipelined in-order instruction fetch with credit-limited
//                requests, response buffering and redirect-driven flushing.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import rv_core_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    instr_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    fifo_head;
    fetch_entry_t    push_entry;
    logic [CW:0]     inflight;
    logic            credit_ok;
    logic            req_fire;
    logic            push;
    logic            pop;

    // Buffered plus outstanding words may never exceed the FIFO size, so
    // every response that is kept always has a free slot waiting for it.
    assign inflight       = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign credit_ok      = (inflight < (CW + 1)'(DEPTH));
    assign imem_req_valid = !reset && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses owed to a pre-redirect stream are swallowed via drop_cnt.
    assign push = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid
                  && (!fifo_full || pop);
    assign pop  = instr_valid && instr_ready && !redirect_valid;

    assign push_entry  = '{instr: imem_rsp_data, pc: rsp_pc_q};
    assign instr_valid = !fifo_empty;
    assign instr       = fifo_head.instr;
    assign instr_pc    = fifo_head.pc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Next-state for fetch/response PCs and the in-flight bookkeeping.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_cnt_d    = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            // Everything still owed after this cycle belongs to the old stream.
            drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
            if (push)     rsp_pc_d   = rsp_pc_q + PC_STEP;
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
    end

    // State registers; reset restarts fetch at RESET_PC with nothing in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

endmodule
`default_nettype wire
